inst_dec_buf: RTL and testbench

INST_DEC_BUF -- requirements
Module: inst_dec_buf

---
 rtl/inst_dec_buf_if.sv | 32 +++
 rtl/inst_dec_buf.sv | 109 ++++++++++
 tb/tb_inst_dec_buf.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/inst_dec_buf_if.sv
// rtl/inst_dec_buf_if.sv - fetch/execute handshake and head-decode bundle for inst_dec_buf
interface inst_dec_buf_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  out_fmt;
    logic [11:0] out_op;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_fmt, out_op,
               out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_fmt, out_op,
               out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm, out_illegal
    );
endinterface

// File: rtl/inst_dec_buf.sv
// rtl/inst_dec_buf.sv - circular instruction FIFO with combinational RV32I decode of the head
module inst_dec_buf #(
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rstB,
    input  logic            clkEn,
    input  logic            flush,
    inst_dec_buf_if.slave   bus,
    output logic [CNTW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [63:0]     mem_q [DEPTH];
    logic            push, pop;

    // Ready/valid come from registered count (and flush) only: no pop-to-ready path.
    always_comb begin
        bus.in_ready  = (cnt_q != CNTW'(DEPTH)) && !flush;
        bus.out_valid = (cnt_q != '0);
        push          = clkEn && bus.in_valid && bus.in_ready;
        pop           = clkEn && bus.out_valid && bus.out_ready && !flush;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (flush) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      cnt_d = cnt_q + CNTW'(1);
            else if (pop && !push) cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage is deliberately unreset; it is masked by out_valid below.
    always_ff @(posedge clk) begin
        if (rstB && push) mem_q[wr_ptr_q] <= {bus.in_instr, bus.in_pc};
    end

    assign count = cnt_q;

    logic [31:0] instr;
    logic [6:0]  opc;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld;
    logic        is_opimm, is_shf, is_st, is_op, is_fence, is_sys;

    always_comb begin
        instr         = bus.out_valid ? mem_q[rd_ptr_q][63:32] : NOP;
        bus.out_instr = instr;
        bus.out_pc    = bus.out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
        opc           = instr[6:0];
        is_lui        = (opc == 7'b0110111);
        is_auipc      = (opc == 7'b0010111);
        is_jal        = (opc == 7'b1101111);
        is_jalr       = (opc == 7'b1100111);
        is_br         = (opc == 7'b1100011);
        is_ld         = (opc == 7'b0000011);
        is_opimm      = (opc == 7'b0010011);
        is_shf        = is_opimm && (instr[13:12] == 2'b01);
        is_st         = (opc == 7'b0100011);
        is_op         = (opc == 7'b0110011);
        is_fence      = (opc == 7'b0001111);
        is_sys        = (opc == 7'b1110011);

        bus.out_op  = {is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld,
                       is_opimm && !is_shf, is_shf, is_st, is_op, is_fence, is_sys};
        bus.out_fmt = {is_op,
                       is_jalr | is_ld | is_opimm | is_fence | is_sys,
                       is_st, is_br, is_jal, is_lui | is_auipc};
        bus.out_illegal = (bus.out_op == '0);

        bus.out_rd     = instr[11:7];
        bus.out_rs1    = instr[19:15];
        bus.out_rs2    = instr[24:20];
        bus.out_funct3 = instr[14:12];
        bus.out_funct7 = instr[31:25];

        bus.out_imm = 32'h0;
        unique case (1'b1)
            bus.out_fmt[4]: bus.out_imm = {{20{instr[31]}}, instr[31:20]};
            bus.out_fmt[3]: bus.out_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            bus.out_fmt[2]: bus.out_imm = {{19{instr[31]}}, instr[31], instr[7],
                                           instr[30:25], instr[11:8], 1'b0};
            bus.out_fmt[1]: bus.out_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                           instr[20], instr[30:21], 1'b0};
            bus.out_fmt[0]: bus.out_imm = {instr[31:12], 12'h000};
            default:        bus.out_imm = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_inst_dec_buf.sv
// tb/tb_inst_dec_buf.sv - directed self-checking bench for inst_dec_buf
module tb_inst_dec_buf;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rstB, clkEn, flush;
    logic [CNTW-1:0] count;
    int              n_checks = 0;
    int              n_fail   = 0;

    inst_dec_buf_if bus ();

    inst_dec_buf #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rstB  (rstB),
        .clkEn (clkEn),
        .flush (flush),
        .bus   (bus.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    logic [63:0] q[$];
    int          mcount;
    int          seq;
    logic        push_e, pop_e;

    initial begin
        rstB = 1'b0; clkEn = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        tick(); tick();
        rstB = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_count",     32'(count), 32'd0);
        check("rst_instr",     bus.out_instr, 32'h13);
        check("rst_pc",        bus.out_pc, 32'h0);
        check("rst_op",        32'(bus.out_op), 32'h020);
        check("rst_fmt",       32'(bus.out_fmt), 32'h10);
        check("rst_illegal",   32'(bus.out_illegal), 32'd0);

        // addi x1,x0,5 at 0x100; must not fall through in the push cycle
        bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0093; bus.in_pc = 32'h100;
        #1;
        check("nofall_valid", 32'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("addi_valid", 32'(bus.out_valid), 32'd1);
        check("addi_fmt",   32'(bus.out_fmt), 32'h10);
        check("addi_rd",    32'(bus.out_rd), 32'd1);
        check("addi_imm",   bus.out_imm, 32'd5);
        check("addi_pc",    bus.out_pc, 32'h100);
        check("addi_count", 32'(count), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("addi_pop_count", 32'(count), 32'd0);

        // fill to DEPTH, extra offer is dropped, drain in order
        for (int k = 0; k < DEPTH; k++) push(32'h0000_0013 | (k << 20), 32'h200 + 4 * k);
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_ready", 32'(bus.in_ready), 32'd0);
        push(32'hDEAD_0013, 32'hBAD);
        check("full_drop_count", 32'(count), 32'(DEPTH));
        bus.out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_instr", bus.out_instr, 32'h0000_0013 | (k << 20));
            check("drain_pc",    bus.out_pc, 32'h200 + 4 * k);
            tick();
        end
        bus.out_ready = 1'b0;
        check("drain_empty", 32'(bus.out_valid), 32'd0);

        // full streaming across pointer wrap, scoreboarded
        seq = 0; mcount = 0; q.delete();
        for (int k = 0; k < DEPTH; k++) begin
            q.push_back({32'h0000_0013 | (seq << 20), 32'h1000 + 4 * seq});
            push(32'h0000_0013 | (seq << 20), 32'h1000 + 4 * seq);
            seq++; mcount++;
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h0000_0013 | (seq << 20);
            bus.in_pc    = 32'h1000 + 4 * seq;
            #1;
            push_e = (mcount < DEPTH);
            pop_e  = (mcount > 0);
            check("stream_ready", 32'(bus.in_ready), 32'(push_e));
            if (pop_e) begin
                check("stream_instr", bus.out_instr, q[0][63:32]);
                void'(q.pop_front());
            end
            if (push_e) begin
                q.push_back({bus.in_instr, bus.in_pc});
                seq++;
            end
            mcount = mcount + int'(push_e) - int'(pop_e);
            tick();
        end
        bus.in_valid = 1'b0;
        check("stream_count", 32'(count), 32'(mcount));
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            check("stream_tail_instr", bus.out_instr, q[0][63:32]);
            check("stream_tail_pc",    bus.out_pc, q[0][31:0]);
            void'(q.pop_front());
            tick();
        end
        bus.out_ready = 1'b0;
        check("stream_empty", 32'(count), 32'd0);

        // flush with 3 buffered and a concurrent push
        for (int k = 0; k < 3; k++) push(32'h0000_0033, 32'h300 + 4 * k);
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h0000_00B7;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_instr", bus.out_instr, 32'h13);

        // immediates and illegal
        push(32'hFE00_0EE3, 32'h400);
        push(32'h8000_0EE3, 32'h404);
        push(32'h8000_00B7, 32'h408);
        push(32'h0000_007F, 32'h40C);
        bus.out_ready = 1'b1;
        check("beq_imm", bus.out_imm, 32'hFFFF_FFFC);
        check("beq_fmt", 32'(bus.out_fmt), 32'h04);
        check("beq_op",  32'(bus.out_op), 32'h080);
        tick();
        check("beq2_imm", bus.out_imm, 32'hFFFF_F81C);
        tick();
        check("lui_imm", bus.out_imm, 32'h8000_0000);
        check("lui_op",  32'(bus.out_op), 32'h800);
        check("lui_fmt", 32'(bus.out_fmt), 32'h01);
        tick();
        check("ill_flag", 32'(bus.out_illegal), 32'd1);
        check("ill_op",   32'(bus.out_op), 32'h0);
        check("ill_fmt",  32'(bus.out_fmt), 32'h0);
        check("ill_imm",  bus.out_imm, 32'h0);
        check("ill_valid", 32'(bus.out_valid), 32'd1);
        tick();
        bus.out_ready = 1'b0;
        check("ill_popped", 32'(count), 32'd0);

        // clkEn=0 freezes everything; flush still empties
        push(32'h0070_0113, 32'h500);
        push(32'h0000_0033, 32'h504);
        clkEn = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h0000_006F; bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check("hold_count", 32'(count), 32'd2);
        check("hold_instr", bus.out_instr, 32'h0070_0113);
        check("hold_pc",    bus.out_pc, 32'h500);
        flush = 1'b1;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; clkEn = 1'b1;
        check("hold_flush_count", 32'(count), 32'd0);
        check("hold_flush_valid", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
